attempt_lockout: RTL and testbench

//  Downstream of the PIN checker. Watches its correct/incorrect LED outputs and counts failed PIN entries.

---
 rtl/attempt_lockout.sv | 110 +++++++++++
 tb/tb_attempt_lockout.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/attempt_lockout.sv
// Failed-PIN attempt limiter: counts incorrect PIN results, imposes timed lockouts,
// and retains the card permanently after too many lockouts.
module attempt_lockout #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 50_000_000,
  parameter int CNT_W        = 26,
  parameter int MAX_LOCKS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       submit_in,
  input  logic       correct,
  input  logic       incorrect,
  output logic       submit_out,
  output logic [2:0] attempts_left,
  output logic       locked,
  output logic       retained,
  output logic       access_ok,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    READY    = 2'd0,
    LOCKOUT  = 2'd1,
    RETAINED = 2'd2
  } state_t;

  localparam logic [2:0]       MAX_A     = 3'(MAX_ATTEMPTS);
  localparam logic [2:0]       MAX_L     = 3'(MAX_LOCKS);
  localparam logic [CNT_W-1:0] TIMER_TOP = CNT_W'(LOCK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       fail_cnt, fail_nxt;
  logic [2:0]       lock_cnt, lock_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             correct_q, incorrect_q;
  logic             access_nxt;
  logic             cor_rise, inc_rise;

  assign cor_rise = correct & ~correct_q;
  assign inc_rise = incorrect & ~incorrect_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= READY;
      fail_cnt    <= '0;
      lock_cnt    <= '0;
      timer       <= '0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      access_ok   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fail_cnt    <= fail_nxt;
      lock_cnt    <= lock_nxt;
      timer       <= timer_nxt;
      correct_q   <= correct;
      incorrect_q <= incorrect;
      access_ok   <= access_nxt;
    end
  end

  // A simultaneous correct/incorrect rise is treated as a failure.
  always_comb begin
    state_nxt  = state;
    fail_nxt   = fail_cnt;
    lock_nxt   = lock_cnt;
    timer_nxt  = timer;
    access_nxt = 1'b0;
    case (state)
      READY: begin
        if (inc_rise) begin
          if (fail_cnt + 3'd1 < MAX_A) begin
            fail_nxt = fail_cnt + 3'd1;
          end else if (lock_cnt + 3'd1 >= MAX_L) begin
            fail_nxt  = MAX_A;
            lock_nxt  = MAX_L;
            state_nxt = RETAINED;
          end else begin
            fail_nxt  = MAX_A;
            lock_nxt  = lock_cnt + 3'd1;
            timer_nxt = TIMER_TOP;
            state_nxt = LOCKOUT;
          end
        end else if (cor_rise) begin
          fail_nxt   = '0;
          lock_nxt   = '0;
          access_nxt = 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          fail_nxt  = '0;
          state_nxt = READY;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      RETAINED: state_nxt = RETAINED;
      default:  state_nxt = RETAINED;
    endcase
  end

  assign submit_out    = submit_in & (state == READY);
  assign locked        = (state == LOCKOUT);
  assign retained      = (state == RETAINED);
  assign attempts_left = (state == READY) ? (MAX_A - fail_cnt) : 3'd0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_attempt_lockout.sv
// Randomized and directed bench for attempt_lockout against a remaining-cycles reference model.
module tb_attempt_lockout;

  localparam int MAX_ATTEMPTS = 3;
  localparam int LOCK_CYCLES  = 8;
  localparam int CNT_W        = 4;
  localparam int MAX_LOCKS    = 2;

  logic       clk = 1'b0;
  logic       reset, submit_in, correct, incorrect;
  logic       submit_out, locked, retained, access_ok;
  logic [2:0] attempts_left;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of failures/lockouts and remaining locked cycles.
  int m_fails, m_locks, m_lock_left;
  bit m_ret, m_acc, m_pc, m_pi;

  attempt_lockout #(
    .MAX_ATTEMPTS(MAX_ATTEMPTS),
    .LOCK_CYCLES (LOCK_CYCLES),
    .CNT_W       (CNT_W),
    .MAX_LOCKS   (MAX_LOCKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .submit_in    (submit_in),
    .correct      (correct),
    .incorrect    (incorrect),
    .submit_out   (submit_out),
    .attempts_left(attempts_left),
    .locked       (locked),
    .retained     (retained),
    .access_ok    (access_ok),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit i);
    bit cr, ir;
    if (r) begin
      m_fails = 0; m_locks = 0; m_lock_left = 0;
      m_ret = 0; m_acc = 0; m_pc = 0; m_pi = 0;
      return;
    end
    cr = c & ~m_pc;
    ir = i & ~m_pi;
    m_pc = c;
    m_pi = i;
    m_acc = 0;
    if (m_ret) begin
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (ir) begin
      if (m_fails + 1 < MAX_ATTEMPTS) m_fails++;
      else if (m_locks + 1 == MAX_LOCKS) m_ret = 1;
      else begin
        m_locks++;
        m_lock_left = LOCK_CYCLES;
      end
    end else if (cr) begin
      m_fails = 0;
      m_locks = 0;
      m_acc = 1;
    end
  endtask

  // Driver: apply inputs, check the combinational gate, clock, then check registered outputs.
  task automatic cycle(input bit r, input bit s, input bit c, input bit i);
    int exp_left;
    bit ready;
    reset = r; submit_in = s; correct = c; incorrect = i;
    #1;
    ready = !m_ret && (m_lock_left == 0);
    check("submit_out", 32'(submit_out), 32'(s & ready));
    @(posedge clk);
    model_step(r, c, i);
    @(negedge clk);
    ready = !m_ret && (m_lock_left == 0);
    exp_left = ready ? (MAX_ATTEMPTS - m_fails) : 0;
    check("attempts_left", 32'(attempts_left), 32'(exp_left));
    check("locked", 32'(locked), 32'(m_lock_left > 0));
    check("retained", 32'(retained), 32'(m_ret));
    check("access_ok", 32'(access_ok), 32'(m_acc));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 1'($urandom_range(0, 1)), 0, 0);
  endtask

  task automatic inc_pulse(input int hold);
    for (int k = 0; k < hold; k++) cycle(0, 0, 0, 1);
    idle(2);
  endtask

  task automatic cor_pulse(input int hold);
    for (int k = 0; k < hold; k++) cycle(0, 0, 1, 0);
    idle(2);
  endtask

  initial begin
    bit c, i, r;
    m_fails = 0; m_locks = 0; m_lock_left = 0;
    m_ret = 0; m_acc = 0; m_pc = 0; m_pi = 0;
    reset = 1; submit_in = 0; correct = 0; incorrect = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);

    // Correct held 5 cycles: single access pulse
    cor_pulse(5);
    // Three failures lead to lockout, then recovery
    for (int k = 0; k < 3; k++) inc_pulse(4);
    for (int k = 0; k < LOCK_CYCLES + 2; k++) cycle(0, 1, 0, 0);
    // Second lockout without a correct in between: retention
    for (int k = 0; k < 3; k++) inc_pulse(4);
    cor_pulse(3);
    idle(4);
    cycle(1, 0, 0, 0);
    idle(2);
    // Correct clears the lockout history
    inc_pulse(4); inc_pulse(4); cor_pulse(4);
    for (int k = 0; k < 3; k++) inc_pulse(4);
    idle(LOCK_CYCLES + 2);
    // Simultaneous rise counts as one failure
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1);
    idle(2);
    // Reset in the middle of a lockout
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) inc_pulse(1);
    idle(2);
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1'(k), 0, 0);

    // Random level traffic with occasional resets
    c = 0; i = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) c = ~c;
      if ($urandom_range(0, 5) == 0) i = ~i;
      r = ($urandom_range(0, 199) == 0);
      cycle(r, 1'($urandom_range(0, 1)), c, i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
